// File: rtl/qspi_target_resp_pkg.sv
// -----------------------------------------------------------------------------
// qspi_pkg
// Shared definitions for the quad-SPI target responder.
//   - Opcode constants for the recognized commands.
//   - FSM state encoding.
//   - Nibble counts for the opcode and address phases.
// No ports (package).
// -----------------------------------------------------------------------------
package qspi_pkg;

  localparam logic [7:0] OP_WRITE     = 8'h02;
  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_ERASE     = 8'h20;

  localparam int OP_NIBBLES   = 2;
  localparam int ADDR_NIBBLES = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OPCODE = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_WDATA  = 3'd4,
    ST_RDATA  = 3'd5,
    ST_IGNORE = 3'd6,
    ST_ERASE  = 3'd7
  } qspi_state_e;

endpackage

// File: rtl/qspi_target_resp_if.sv
// -----------------------------------------------------------------------------
// qspi_target_resp_if
// Bus-side bundle of the quad-SPI link between a controller and this target.
//   CS     : chip select, active low (controller -> target)
//   SCLK   : serial clock, mode 0 (controller -> target)
//   io_i   : IO[3:0] as seen on the bus (controller -> target)
//   io_o   : IO[3:0] value the target drives during read data
//   io_oe  : target output enable; the top level builds the tri-state
// Modports: slave (the target), master (the controller / bench).
// -----------------------------------------------------------------------------
interface qspi_target_resp_if;
  logic       CS;
  logic       SCLK;
  logic [3:0] io_i;
  logic [3:0] io_o;
  logic       io_oe;

  modport slave  (input  CS, SCLK, io_i, output io_o, io_oe);
  modport master (output CS, SCLK, io_i, input  io_o, io_oe);
endinterface

// File: rtl/qspi_target_resp_sync_edge.sv
// -----------------------------------------------------------------------------
// qspi_sync_edge
// Brings CS, SCLK and IO into the system clock domain and derives edge pulses.
//   clk, reset_n      : system clock, asynchronous active-low reset
//   i_cs, i_sclk, i_io: raw bus inputs
//   o_cs, o_io        : synchronized CS level and IO nibble
//   o_sclk_rise/fall  : one-clk SCLK edge pulses, only while synced CS is low
//   o_cs_fall/rise    : one-clk CS edge pulses
// IO goes through the same number of stages as SCLK, so o_io is aligned with
// the rise pulse that samples it.
// -----------------------------------------------------------------------------
module qspi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_cs,
  input  logic       i_sclk,
  input  logic [3:0] i_io,
  output logic       o_cs,
  output logic [3:0] o_io,
  output logic       o_sclk_rise,
  output logic       o_sclk_fall,
  output logic       o_cs_fall,
  output logic       o_cs_rise
);

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [3:0]             r_io_sync [SYNC_STAGES];
  logic                   r_cs_prev;
  logic                   r_sclk_prev;
  logic                   w_cs;
  logic                   w_sclk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cs_sync   <= '1;
      r_sclk_sync <= '0;
      r_cs_prev   <= 1'b1;
      r_sclk_prev <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) r_io_sync[i] <= 4'h0;
    end else begin
      r_cs_sync[0]   <= i_cs;
      r_sclk_sync[0] <= i_sclk;
      r_io_sync[0]   <= i_io;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_cs_sync[i]   <= r_cs_sync[i-1];
        r_sclk_sync[i] <= r_sclk_sync[i-1];
        r_io_sync[i]   <= r_io_sync[i-1];
      end
      r_cs_prev   <= w_cs;
      r_sclk_prev <= w_sclk;
    end
  end

  assign w_cs   = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];

  assign o_cs        = w_cs;
  assign o_io        = r_io_sync[SYNC_STAGES-1];
  // SCLK activity while deselected is not ours to act on.
  assign o_sclk_rise = w_sclk & ~r_sclk_prev & ~w_cs;
  assign o_sclk_fall = ~w_sclk & r_sclk_prev & ~w_cs;
  assign o_cs_fall   = ~w_cs & r_cs_prev;
  assign o_cs_rise   = w_cs & ~r_cs_prev;

endmodule

// File: rtl/qspi_target_resp.sv
// -----------------------------------------------------------------------------
// qspi_target_resp
// Quad-SPI flash-like target: decodes opcode/address/dummy phases from an
// oversampled bus and serves quad reads from / writes to a local byte memory.
// Commands: 0x02 write, 0x03 read, 0x0B fast read (DUMMY_CYCLES dummy clocks).
// Optional build macro QSPI_TARGET_ERASE_EN adds opcode 0x20 (erase all to
// 0xFF after CS rises, one byte per clk).
// Ports:
//   clk, reset_n : system clock (>= 8x SCLK), asynchronous active-low reset
//   bus          : qspi_target_resp_if.slave (CS, SCLK, io_i, io_o, io_oe)
//   busy         : state is not IDLE
//   cmd_done     : one-clk pulse when a recognized command completes
//   last_opcode  : opcode of the most recent command
//   bad_opcode   : sticky flag for an unknown opcode, cleared only by reset
// -----------------------------------------------------------------------------
module qspi_target_resp
  import qspi_pkg::*;
#(
  parameter int MEM_DEPTH    = 256,
  parameter int DUMMY_CYCLES = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  qspi_target_resp_if.slave        bus,
  output logic                     busy,
  output logic                     cmd_done,
  output logic [7:0]               last_opcode,
  output logic                     bad_opcode
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic        w_cs;
  logic [3:0]  w_io;
  logic        w_sclk_rise;
  logic        w_sclk_fall;
  logic        w_cs_fall;
  logic        w_cs_rise;

  qspi_state_e r_state;
  qspi_state_e w_state_nxt;

  logic [7:0]    r_cnt;
  logic [3:0]    r_op_hi;
  logic [7:0]    w_op_full;
  logic          w_op_known;
  logic          w_op_done;
  logic          w_addr_done;
  logic          w_dummy_done;
  logic          w_erase_done;
  logic [AW-1:0] r_addr;
  logic [3:0]    r_whi;
  logic          r_wr_lo;
  logic          r_rd_lo;
  logic          r_cmd_ok;
  logic [AW-1:0] r_erase_cnt;
  logic [3:0]    r_io_o;
  logic          r_io_oe;
  logic          r_cmd_done;
  logic [7:0]    r_last_opcode;
  logic          r_bad_opcode;
`ifdef QSPI_TARGET_ERASE_EN
  logic          r_erase_pend;
`endif

  logic [7:0]    r_mem [MEM_DEPTH];
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [7:0]    w_wdata;
  logic [7:0]    w_rbyte;

  qspi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_cs        (bus.CS),
    .i_sclk      (bus.SCLK),
    .i_io        (bus.io_i),
    .o_cs        (w_cs),
    .o_io        (w_io),
    .o_sclk_rise (w_sclk_rise),
    .o_sclk_fall (w_sclk_fall),
    .o_cs_fall   (w_cs_fall),
    .o_cs_rise   (w_cs_rise)
  );

  // The opcode is complete on its second nibble, before it is registered.
  assign w_op_full    = {r_op_hi, w_io};
  assign w_op_done    = (r_state == ST_OPCODE) && w_sclk_rise && (r_cnt == 8'(OP_NIBBLES - 1));
  assign w_addr_done  = (r_state == ST_ADDR)   && w_sclk_rise && (r_cnt == 8'(ADDR_NIBBLES - 1));
  assign w_dummy_done = (r_state == ST_DUMMY)  && w_sclk_rise && (r_cnt == 8'(DUMMY_CYCLES - 1));
  assign w_erase_done = (r_state == ST_ERASE)  && (r_erase_cnt == AW'(MEM_DEPTH - 1));

  always_comb begin
    w_op_known = 1'b0;
    case (w_op_full)
      OP_WRITE, OP_READ, OP_FAST_READ: w_op_known = 1'b1;
`ifdef QSPI_TARGET_ERASE_EN
      OP_ERASE:                        w_op_known = 1'b1;
`endif
      default:                         w_op_known = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state. An erase in progress runs to completion regardless of CS;
  // otherwise CS rising always returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_ERASE) begin
      if (w_erase_done) w_state_nxt = w_cs ? ST_IDLE : ST_IGNORE;
    end else if (w_cs_rise) begin
`ifdef QSPI_TARGET_ERASE_EN
      w_state_nxt = r_erase_pend ? ST_ERASE : ST_IDLE;
`else
      w_state_nxt = ST_IDLE;
`endif
    end else begin
      case (r_state)
        ST_IDLE:   if (w_cs_fall) w_state_nxt = ST_OPCODE;
        ST_OPCODE: if (w_op_done)
                     w_state_nxt = (w_op_known && (w_op_full != OP_ERASE)) ? ST_ADDR : ST_IGNORE;
        ST_ADDR:   if (w_addr_done) begin
                     case (r_last_opcode)
                       OP_WRITE:     w_state_nxt = ST_WDATA;
                       OP_READ:      w_state_nxt = ST_RDATA;
                       default:      w_state_nxt = (DUMMY_CYCLES == 0) ? ST_RDATA : ST_DUMMY;
                     endcase
                   end
        ST_DUMMY:  if (w_dummy_done) w_state_nxt = ST_RDATA;
        default:   ;
      endcase
    end
  end

  // Single memory write port shared by WDATA and erase.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_addr;
    w_wdata = {r_whi, w_io};
    if (r_state == ST_ERASE) begin
      w_we    = 1'b1;
      w_waddr = r_erase_cnt;
      w_wdata = 8'hFF;
    end else if ((r_state == ST_WDATA) && w_sclk_rise && r_wr_lo && !w_cs_rise) begin
      w_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  assign w_rbyte = r_mem[r_addr];

  // Phase counters, address, read/write nibble tracking and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt         <= 8'h00;
      r_op_hi       <= 4'h0;
      r_addr        <= '0;
      r_whi         <= 4'h0;
      r_wr_lo       <= 1'b0;
      r_rd_lo       <= 1'b0;
      r_cmd_ok      <= 1'b0;
      r_erase_cnt   <= '0;
      r_io_o        <= 4'h0;
      r_io_oe       <= 1'b0;
      r_cmd_done    <= 1'b0;
      r_last_opcode <= 8'h00;
      r_bad_opcode  <= 1'b0;
`ifdef QSPI_TARGET_ERASE_EN
      r_erase_pend  <= 1'b0;
`endif
    end else begin
      r_cmd_done <= 1'b0;

      if (w_state_nxt != r_state) r_cnt <= 8'h00;
      else if (w_sclk_rise)       r_cnt <= r_cnt + 8'd1;

      if ((r_state == ST_IDLE) && w_cs_fall) begin
        r_cmd_ok <= 1'b0;
        r_wr_lo  <= 1'b0;
        r_rd_lo  <= 1'b0;
      end

      if ((r_state == ST_OPCODE) && w_sclk_rise) r_op_hi <= w_io;

      if (w_op_done) begin
        r_last_opcode <= w_op_full;
        if (!w_op_known) r_bad_opcode <= 1'b1;
      end

      if ((r_state == ST_ADDR) && w_sclk_rise) r_addr <= AW'({r_addr, w_io});
      if (w_addr_done) r_cmd_ok <= 1'b1;

      // First nibble of a byte is held; the pair is written on the second.
      if ((r_state == ST_WDATA) && w_sclk_rise) begin
        r_wr_lo <= ~r_wr_lo;
        if (!r_wr_lo) r_whi  <= w_io;
        else          r_addr <= r_addr + AW'(1);
      end

      if ((r_state == ST_RDATA) && w_sclk_fall) begin
        r_io_oe <= 1'b1;
        r_rd_lo <= ~r_rd_lo;
        if (r_rd_lo) begin
          r_io_o <= w_rbyte[3:0];
          r_addr <= r_addr + AW'(1);
        end else begin
          r_io_o <= w_rbyte[7:4];
        end
      end

      if (w_cs_rise && (r_state != ST_ERASE)) begin
        r_io_oe    <= 1'b0;
        r_cmd_done <= r_cmd_ok;
        r_cmd_ok   <= 1'b0;
      end

      if (r_state == ST_ERASE) r_erase_cnt <= r_erase_cnt + AW'(1);
      else                     r_erase_cnt <= '0;

      // A frame started while erasing was never decoded; flag it as bad.
      if (w_erase_done) begin
        r_cmd_done <= 1'b1;
        if (!w_cs) r_bad_opcode <= 1'b1;
      end

`ifdef QSPI_TARGET_ERASE_EN
      if (w_op_done && (w_op_full == OP_ERASE)) r_erase_pend <= 1'b1;
      if (w_cs_rise)                            r_erase_pend <= 1'b0;
`endif
    end
  end

  assign bus.io_o    = r_io_o;
  assign bus.io_oe   = r_io_oe;
  assign busy        = (r_state != ST_IDLE);
  assign cmd_done    = r_cmd_done;
  assign last_opcode = r_last_opcode;
  assign bad_opcode  = r_bad_opcode;

endmodule

// File: tb/tb_qspi_target_resp.sv
// -----------------------------------------------------------------------------
// tb_qspi_target_resp
// Directed bench for qspi_target_resp. Stimulus tasks drive QSPI frames and
// push the expected io_oe/io_o value for every SCLK fall, plus the expected
// opcode for every cmd_done pulse; two monitor processes pop and compare.
// -----------------------------------------------------------------------------
module tb_qspi_target_resp;

  localparam int MEM_DEPTH    = 256;
  localparam int DUMMY_CYCLES = 2;
  localparam int SYNC_STAGES  = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       busy;
  logic       cmd_done;
  logic [7:0] last_opcode;
  logic       bad_opcode;

  qspi_target_resp_if bus();

  qspi_target_resp #(
    .MEM_DEPTH    (MEM_DEPTH),
    .DUMMY_CYCLES (DUMMY_CYCLES),
    .SYNC_STAGES  (SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .busy        (busy),
    .cmd_done    (cmd_done),
    .last_opcode (last_opcode),
    .bad_opcode  (bad_opcode)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  bit         mon_en = 1'b0;
  logic [4:0] q_fall [$];   // {expected io_oe, expected io_o}
  logic [7:0] q_cmd  [$];   // expected last_opcode at each cmd_done

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-fall monitor: io_o/io_oe must settle within SYNC_STAGES+1 clocks.
  initial begin
    logic [4:0] e;
    forever begin
      @(negedge bus.SCLK);
      if (mon_en) begin
        repeat (SYNC_STAGES + 2) @(posedge clk);
        #1;
        if (q_fall.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fall: got io_oe=%0b io_o=%0h expected no SCLK fall", bus.io_oe, bus.io_o);
        end else begin
          e = q_fall.pop_front();
          chk("io_oe", {31'b0, bus.io_oe}, {31'b0, e[4]});
          if (e[4]) chk("io_o", {28'b0, bus.io_o}, {28'b0, e[3:0]});
        end
      end
    end
  end

  // cmd_done monitor
  always @(negedge clk) begin
    if (mon_en && cmd_done) begin
      if (q_cmd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cmd_done_unexpected: got pulse (last_opcode=%0h) expected none", last_opcode);
      end else begin
        chk("cmd_opcode", {24'b0, last_opcode}, {24'b0, q_cmd.pop_front()});
      end
    end
  end

  // One SCLK period (16 clk), mode 0, with the expectation for its fall.
  task automatic cyc(input logic [3:0] nib, input bit oe, input logic [3:0] exp);
    q_fall.push_back({oe, exp});
    bus.io_i = nib;
    repeat (4) @(negedge clk);
    bus.SCLK = 1'b1;
    repeat (8) @(negedge clk);
    bus.SCLK = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // CS low, opcode, n_addr address nibbles, n_dummy dummy, n_data data cycles.
  // Falls from index oe_from on expect io_oe=1 with nibbles of rd, MSB first.
  task automatic frame(input logic [7:0] op, input logic [23:0] a, input int n_addr,
                       input int n_dummy, input int n_data, input logic [63:0] wd,
                       input int oe_from, input logic [31:0] rd);
    int         total;
    logic [3:0] nib;
    bit         oe;
    logic [3:0] ex;
    total = 2 + n_addr + n_dummy + n_data;
    bus.CS = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < total; i++) begin
      if (i < 2)                           nib = op[7 - 4*i -: 4];
      else if (i < 2 + n_addr)             nib = a[23 - 4*(i-2) -: 4];
      else if (i < 2 + n_addr + n_dummy)   nib = 4'h5;
      else                                 nib = wd[63 - 4*(i-2-n_addr-n_dummy) -: 4];
      oe = (oe_from >= 0) && (i >= oe_from);
      ex = 4'h0;
      if (oe) ex = rd[31 - 4*(i-oe_from) -: 4];
      cyc(nib, oe, ex);
    end
  endtask

  task automatic end_frame(input bit exp_cmd, input logic [7:0] op);
    if (exp_cmd) q_cmd.push_back(op);
    bus.CS = 1'b1;
    repeat (8) @(negedge clk);
    chk("fall_q_drained", q_fall.size(), 0);
    chk("cmd_q_drained",  q_cmd.size(),  0);
    chk("busy_after",     {31'b0, busy},      0);
    chk("oe_after",       {31'b0, bus.io_oe}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bus.CS   = 1'b1;
    bus.SCLK = 1'b0;
    bus.io_i = 4'h0;
    reset_n  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_io_o",        {28'b0, bus.io_o},    0);
    chk("rst_io_oe",       {31'b0, bus.io_oe},   0);
    chk("rst_busy",        {31'b0, busy},        0);
    chk("rst_cmd_done",    {31'b0, cmd_done},    0);
    chk("rst_last_opcode", {24'b0, last_opcode}, 0);
    chk("rst_bad_opcode",  {31'b0, bad_opcode},  0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    mon_en = 1'b1;

    // Write A5 3C at 0x10
    frame(8'h02, 24'h000010, 6, 0, 4, 64'hA53C_0000_0000_0000, -1, 32'h0);
    end_frame(1'b1, 8'h02);
    chk("last_opcode_wr", {24'b0, last_opcode}, 32'h02);

    // Read 4 nibbles; first driven on the fall after the 6th address rise
    frame(8'h03, 24'h000010, 6, 0, 3, 64'h0, 7, 32'hA53C_0000);
    end_frame(1'b1, 8'h03);

    // Fast read: two dummy clocks with io_oe low
    frame(8'h0B, 24'h000010, 6, DUMMY_CYCLES, 1, 64'h0, 8 + DUMMY_CYCLES - 1, 32'hA500_0000);
    end_frame(1'b1, 8'h0B);

    // Write wrapping past the top of memory
    frame(8'h02, 24'h0000FF, 6, 0, 4, 64'h1122_0000_0000_0000, -1, 32'h0);
    end_frame(1'b1, 8'h02);
    frame(8'h03, 24'h0000FF, 6, 0, 3, 64'h0, 7, 32'h1122_0000);
    end_frame(1'b1, 8'h03);
    frame(8'h03, 24'h000000, 6, 0, 1, 64'h0, 7, 32'h2200_0000);
    end_frame(1'b1, 8'h03);

    // Unknown opcode: no cmd_done, io_oe low, sticky bad_opcode
    frame(8'h9F, 24'h0, 0, 0, 4, 64'hDEAD_0000_0000_0000, -1, 32'h0);
    end_frame(1'b0, 8'h00);
    chk("bad_opcode_set",   {31'b0, bad_opcode},  1);
    chk("last_opcode_bad",  {24'b0, last_opcode}, 32'h9F);

    // Single write nibble is discarded
    frame(8'h02, 24'h000010, 6, 0, 1, 64'h7000_0000_0000_0000, -1, 32'h0);
    end_frame(1'b1, 8'h02);
    frame(8'h03, 24'h000010, 6, 0, 1, 64'h0, 7, 32'hA500_0000);
    end_frame(1'b1, 8'h03);
    chk("bad_opcode_sticky", {31'b0, bad_opcode}, 1);

    // CS rise during the address phase: no cmd_done
    frame(8'h03, 24'h000010, 3, 0, 0, 64'h0, -1, 32'h0);
    end_frame(1'b0, 8'h00);

    // Reset in the middle of a read burst
    frame(8'h03, 24'h000010, 6, 0, 1, 64'h0, 7, 32'hA500_0000);
    chk("oe_before_reset", {31'b0, bus.io_oe}, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_io_oe", {31'b0, bus.io_oe}, 0);
    chk("rst_mid_busy",  {31'b0, busy},      0);
    chk("rst_mid_io_o",  {28'b0, bus.io_o},  0);
    bus.CS = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_mid_last_opcode", {24'b0, last_opcode}, 0);
    chk("rst_mid_bad_opcode",  {31'b0, bad_opcode},  0);
    chk("rst_mid_fall_q",      q_fall.size(),        0);
    // Memory survives reset
    frame(8'h03, 24'h000010, 6, 0, 1, 64'h0, 7, 32'hA500_0000);
    end_frame(1'b1, 8'h03);

`ifdef QSPI_TARGET_ERASE_EN
    frame(8'h20, 24'h0, 0, 0, 0, 64'h0, -1, 32'h0);
    q_cmd.push_back(8'h20);
    bus.CS = 1'b1;
    cnt = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    chk("erase_busy_len_ok", {31'b0, (cnt >= MEM_DEPTH) && (cnt <= MEM_DEPTH + 6)}, 1);
    repeat (4) @(negedge clk);
    chk("erase_cmd_q", q_cmd.size(), 0);
    frame(8'h03, 24'h000010, 6, 0, 1, 64'h0, 7, 32'hFF00_0000);
    end_frame(1'b1, 8'h03);
`else
    cnt = 0;
`endif

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qspi_target_resp.md
Name: qspi_target_resp

Overview:
- Quad-SPI target (flash-like responder): the far end of the QSPI controller bus that carries CS, SCLK and IO[3:0].
- Oversamples CS, SCLK and IO on the system clock and decodes opcode, address and dummy phases.
- Serves quad-width reads from, and writes to, a local byte memory.
- Used as the bus-side agent/BFM counterpart in the UVM bench and as a synthesizable loopback target.

Parameters:
- MEM_DEPTH, 256: bytes of local memory; power of 2, 16..4096.
- DUMMY_CYCLES, 2: SCLK cycles between the last address nibble and the first read nibble, for opcode 0x0B.
- SYNC_STAGES, 2: synchronizer flops on CS, SCLK and io_i.

Ports:
- clk, input, 1: system clock; must run at ≥8x SCLK.
- reset_n, input, 1: asynchronous active-low reset.
- CS, input, 1: chip select, active low.
- SCLK, input, 1: serial clock, mode 0 (idles low).
- io_i, input, 4: IO lines sampled from the bus.
- io_o, output, 4: IO value driven during read data.
- io_oe, output, 1: IO output enable; the top level builds the tri-state.
- busy, output, 1: high whenever the state is not IDLE.
- cmd_done, output, 1: one-clk pulse on CS rise after a recognized command.
- last_opcode, output, 8: opcode of the most recent command.
- bad_opcode, output, 1: sticky; set on an unknown opcode, cleared by reset only.

Behaviour:
- Reset values: io_o=0, io_oe=0, busy=0, cmd_done=0, last_opcode=0x00, bad_opcode=0, state IDLE.
  - Memory is not reset; contents are undefined until written.
- Input conditioning:
  - CS, SCLK and io_i pass through SYNC_STAGES flops.
  - SCLK rise/fall are detected from the last two synced samples.
  - Rise = sample io_i; fall = update io_o.
- All phases are quad, MSB nibble first.
  - Opcode: 2 SCLK rises.
  - Address: 6 rises, 24 bits; only the low log2(MEM_DEPTH) bits index memory.
- FSM states: IDLE, OPCODE, ADDR, DUMMY, WDATA, RDATA, IGNORE, plus ERASE (optional feature only).
- IDLE -> OPCODE on synced CS falling.
- OPCODE complete (2 nibbles):
  - 0x02 -> ADDR, then WDATA.
  - 0x03 -> ADDR, then RDATA with 0 dummy cycles.
  - 0x0B -> ADDR, then DUMMY, then RDATA.
  - Other -> IGNORE, and set bad_opcode.
- last_opcode loads when the second opcode nibble is captured.
- DUMMY: counts DUMMY_CYCLES rises; bus data is ignored.
- WDATA:
  - Nibble pair forms a byte; the write happens on the second nibble's rise.
  - Address increments and wraps modulo MEM_DEPTH.
- RDATA:
  - io_oe rises on the SCLK fall after the last ADDR/DUMMY rise, with the high nibble of mem[addr] on io_o.
  - The next fall drives the low nibble.
  - Address increments after the low nibble and wraps modulo MEM_DEPTH; the burst continues until CS rises.
- io_o/io_oe update ≤ SYNC_STAGES+1 clk after the SCLK fall edge is present on the pin.
- CS rise (synced) in any state:
  - Next clk: state IDLE and io_oe=0.
  - A partial write byte (one nibble) is discarded.
  - cmd_done pulses if the opcode was recognized and the address phase completed.
- CS rise during OPCODE or ADDR: no memory access and no cmd_done.
- SCLK edges while CS is high are ignored.
- Reset mid-transfer: immediate return to reset values; memory is unchanged.

Optional Feature:
- Macro: QSPI_TARGET_ERASE_EN.
- Defined:
  - Opcode 0x20 (no address) is recognized and last_opcode updates.
  - On CS rise the FSM enters ERASE and writes 0xFF to one location per clk for MEM_DEPTH clks, with busy high.
  - cmd_done pulses at the end of the erase.
  - A CS fall during ERASE is ignored until the erase completes; the whole frame goes to IGNORE and sets bad_opcode.
- Not defined: 0x20 is treated as an unknown opcode.

Decomposition:
- Package qspi_pkg holds:
  - Opcode constants OP_WRITE=0x02, OP_READ=0x03, OP_FAST_READ=0x0B, OP_ERASE=0x20.
  - typedef enum for the FSM state.
  - Nibble count constants: opcode 2, address 6.
- One sub-module, qspi_sync_edge: synchronizes CS, SCLK and io_i and produces sclk_rise, sclk_fall, cs_fall and cs_rise pulses.
- The memory is inferred inside the top module.

Test Plan:
- Write 0x02, addr 0x000010, data A5 3C, CS high -> mem[0x10]=A5, mem[0x11]=3C; cmd_done pulses once; last_opcode=0x02.
- Then read 0x03 at addr 0x000010 for 4 nibbles -> io_o=A,5,3,C, with io_oe asserted from the fall after the 6th address rise.
- Fast read 0x0B at addr 0x10, DUMMY_CYCLES=2 -> io_oe stays 0 for 2 SCLK; first nibble is 0xA.
- Write at addr 0x0FF, 2 bytes 11 22 (MEM_DEPTH=256) -> mem[0xFF]=11, mem[0x00]=22 (wrap).
- Unknown opcode 0x9F, then CS high -> bad_opcode=1 and stays 1; no cmd_done; io_oe=0 throughout. A write of 1 nibble then CS rise -> memory unchanged.
- reset_n low mid-RDATA -> io_oe=0 and busy=0 immediately. With QSPI_TARGET_ERASE_EN, 0x20 -> busy for 256 clk, then a read at addr 0x10 returns 0xFF.
